hilo_muldiv_unit: RTL and testbench

- Execute-stage HI/LO unit; sits directly downstream of the decode-side HI/LO write classifier.
- Owns the architectural HI and LO registers and applies MTHI, MTLO, MULT, MULTU, DIV and DIVU.
- Multiplies run through a fixed-latency counter; divides run through a 32-iteration restoring divider.
- Raises busy/ready so the pipeline stalls MFHI/MFLO and further HI/LO ops until results land.

---
 rtl/hilo_muldiv_unit.sv | 210 +++++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// Execute-stage HI/LO unit: owns HI/LO, applies MTHI/MTLO directly and
// runs MULT/MULTU through a fixed-latency counter and DIV/DIVU through a
// 32-step restoring divider followed by a sign fixup edge.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; MTHI/MTLO complete here on the accept edge
// MUL   | counting to MUL_CYCLES, then {hi,lo} <= 64-bit product
// DIV   | 32 restoring steps, then sign fixup and HI/LO write
module hilo_muldiv_unit #(
  parameter int MUL_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_t;

  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_LAST = 6'd32;

  localparam logic [2:0] OP_MTHI  = 3'd0;
  localparam logic [2:0] OP_MTLO  = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_MULTU = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        signed_q, signed_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;

  logic        accept;
  logic        req_signed;
  logic        req_sign_a;
  logic        req_sign_b;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;

  assign accept     = req_valid & (state_q == ST_IDLE) & ~flush;
  assign req_signed = (req_op == OP_MULT) | (req_op == OP_DIV);
  assign req_sign_a = req_signed & req_a[31];
  assign req_sign_b = req_signed & req_b[31];

  // Low 64 bits of the extended product are correct for both signednesses.
  assign mul_a = signed_q ? {{32{op_a_q[31]}}, op_a_q} : {32'd0, op_a_q};
  assign mul_b = signed_q ? {{32{op_b_q[31]}}, op_b_q} : {32'd0, op_b_q};
  assign prod  = mul_a * mul_b;

  // Restoring step: bit 32 of diff set means the trial subtraction underflowed.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, op_b_q};
  assign quo_fix = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
  assign rem_fix = sign_a_q ? -rem_q : rem_q;

  // Next-state and datapath decode for all three states.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    signed_d = signed_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MTHI: hi_d = req_a;
            OP_MTLO: lo_d = req_a;
            OP_MULT, OP_MULTU: begin
              op_a_d   = req_a;
              op_b_d   = req_b;
              signed_d = req_signed;
              cnt_d    = 6'd1;
              state_d  = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              signed_d = req_signed;
              sign_a_d = req_sign_a;
              sign_b_d = req_sign_b;
              quo_d    = req_sign_a ? -req_a : req_a;
              op_b_d   = req_sign_b ? -req_b : req_b;
              rem_d    = 32'd0;
              cnt_d    = 6'd0;
              state_d  = ST_DIV;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          cnt_d   = 6'd0;
          state_d = ST_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          {hi_d, lo_d} = prod;
          done_d  = 1'b1;
          cnt_d   = 6'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DIV: begin
        if (flush) begin
          cnt_d   = 6'd0;
          state_d = ST_IDLE;
        end else if (cnt_q != DIV_LAST) begin
          if (diff[32]) begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end else begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          // Divide by zero still completes and pulses done, but leaves HI/LO alone.
          if (op_b_q != 32'd0) begin
            lo_d = quo_fix;
            hi_d = rem_fix;
          end
          done_d  = 1'b1;
          cnt_d   = 6'd0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = 6'd0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      signed_q <= 1'b0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      rem_q    <= 32'd0;
      quo_q    <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      signed_q <= signed_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: directed cases plus randomized ops checked
// against an arithmetic reference model of HI/LO and op timing.
module tb_hilo_muldiv_unit;

  localparam int MUL_CYCLES = 2;
  localparam int DIV_CYCLES = 33;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  hilo_muldiv_unit #(.MUL_CYCLES(MUL_CYCLES)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: what HI/LO should become and how many edges the op takes.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic wr, output logic [31:0] nh,
                       output logic [31:0] nl);
    longint sa, sb, p, q, r;
    logic [63:0] pv;
    lat = 0;
    wr  = 1'b0;
    nh  = exp_hi;
    nl  = exp_lo;
    sa  = (op == 3'd2 || op == 3'd4) ? longint'({{32{a[31]}}, a}) : longint'({32'd0, a});
    sb  = (op == 3'd2 || op == 3'd4) ? longint'({{32{b[31]}}, b}) : longint'({32'd0, b});
    case (op)
      3'd0: begin wr = 1'b1; nh = a; end
      3'd1: begin wr = 1'b1; nl = a; end
      3'd2, 3'd3: begin
        lat = MUL_CYCLES;
        wr  = 1'b1;
        p   = sa * sb;
        pv  = 64'(p);
        nh  = pv[63:32];
        nl  = pv[31:0];
      end
      3'd4, 3'd5: begin
        lat = DIV_CYCLES;
        if (b != 32'd0) begin
          wr = 1'b1;
          q  = sa / sb;
          r  = sa % sb;
          nl = 32'(q);
          nh = 32'(r);
        end
      end
      default: ;
    endcase
  endtask

  // Issue one request. flush_n = -1: no flush; -2: flush during the request
  // cycle; k >= 0: flush sampled at the (k+1)-th edge after accept.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_n);
    int lat, busy_cnt, done_cnt, done_at, ready_cnt, exp_busy, exp_done;
    logic wr;
    logic [31:0] nh, nl;
    string t;
    model(op, a, b, lat, wr, nh, nl);
    t = $sformatf("op%0d a=%08h b=%08h f=%0d", op, a, b, flush_n);
    @(negedge clk);
    chk({t, " ready_pre"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    flush     = (flush_n == -2);
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    busy_cnt  = 0;
    done_cnt  = 0;
    done_at   = -1;
    ready_cnt = 0;
    for (int n = 0; n <= lat + 1; n++) begin
      if (busy) busy_cnt++;
      if (req_ready) ready_cnt++;
      if (done) begin
        done_cnt++;
        done_at = n;
      end
      flush = (flush_n >= 0) && (n == flush_n);
      if (n < lat + 1) @(negedge clk);
    end
    flush = 1'b0;
    if (flush_n == -2) begin
      exp_busy = 0;
      exp_done = 0;
      wr       = 1'b0;
    end else if (flush_n >= 0 && lat > 0) begin
      exp_busy = flush_n + 1;
      exp_done = 0;
      wr       = 1'b0;
    end else begin
      exp_busy = lat;
      exp_done = (lat > 0) ? 1 : 0;
    end
    if (wr) begin
      exp_hi = nh;
      exp_lo = nl;
    end
    chk({t, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    chk({t, " ready_cycles"}, 64'(ready_cnt), 64'(lat + 2 - exp_busy));
    chk({t, " done_pulses"}, 64'(done_cnt), 64'(exp_done));
    if (exp_done == 1) chk({t, " done_edge"}, 64'(done_at), 64'(lat));
    chk({t, " hi"}, 64'(hi), 64'(exp_hi));
    chk({t, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    int          r_f, lat_r;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
    flush     = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset ready", 64'(req_ready), 64'd1);

    run_op(3'd0, 32'h12345678, 32'h0, -1);
    run_op(3'd1, 32'h9ABCDEF0, 32'h0, -1);
    run_op(3'd2, 32'hFFFFFFFE, 32'd3, -1);
    run_op(3'd3, 32'hFFFFFFFE, 32'd3, -1);
    run_op(3'd4, 32'hFFFFFFF9, 32'd2, -1);
    run_op(3'd5, 32'd100, 32'd7, -1);
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, -1);
    run_op(3'd0, 32'hAAAAAAAA, 32'h0, -1);
    run_op(3'd1, 32'hAAAAAAAA, 32'h0, -1);
    run_op(3'd5, 32'd5, 32'd0, -1);
    run_op(3'd5, 32'd1000, 32'd9, 10);
    run_op(3'd5, 32'd1000, 32'd9, 32);
    run_op(3'd2, 32'd7, 32'd9, 1);
    run_op(3'd3, 32'd7, 32'd9, 0);
    run_op(3'd0, 32'h55555555, 32'h0, -2);
    run_op(3'd1, 32'h55555555, 32'h0, -2);
    run_op(3'd6, 32'h11111111, 32'h2, -1);
    run_op(3'd7, 32'h11111111, 32'h2, -1);

    // Async reset in the middle of a divide.
    run_op(3'd0, 32'hDEADBEEF, 32'h0, -1);
    run_op(3'd1, 32'hCAFEF00D, 32'h0, -1);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd4;
    req_a     = 32'd100;
    req_b     = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset hi", 64'(hi), 64'd0);
    chk("midreset lo", 64'(lo), 64'd0);
    chk("midreset busy", 64'(busy), 64'd0);
    chk("midreset done", 64'(done), 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    run_op(3'd2, 32'd3, 32'd4, -1);

    for (int i = 0; i < 50; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      case ($urandom_range(0, 5))
        0: r_b = 32'd0;
        1: r_b = 32'hFFFFFFFF;
        2: r_b = 32'($urandom_range(1, 20));
        default: r_b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) r_a = 32'h80000000;
      lat_r = (r_op == 3'd2 || r_op == 3'd3) ? MUL_CYCLES :
              (r_op == 3'd4 || r_op == 3'd5) ? DIV_CYCLES : 0;
      r_f = -1;
      if ($urandom_range(0, 4) == 0) begin
        if (lat_r > 0) r_f = $urandom_range(0, lat_r - 1);
        else r_f = -2;
      end
      run_op(r_op, r_a, r_b, r_f);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
